// File: rtl/dmem_arbiter_if.sv
// Bundle of signals between the data-memory arbiter, its two requesters and
// the single-port memory.
//   slave  : arbiter side (takes requests and memory read data; drives grants,
//            read-return signals and the memory command)
//   master : environment side (the CPU/DMA requesters plus the memory model)
// Port 0 = CPU data port, port 1 = loader/debug DMA port.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          mwe;
  logic [DW-1:0] mrdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mrdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output maddr, mwdata, mwe
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mrdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  maddr, mwdata, mwe
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Grants are registered (one cycle arbitration latency). While a port holds
// the grant, every cycle with its request high is one memory transfer: writes
// commit at the closing edge, reads are captured into rdata at that edge and
// flagged by a one-cycle rvalid pulse. A port may keep the grant for at most
// MAX_HOLD transfers while the other port is requesting.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - dmem_arbiter_if.slave (request ports 0/1, rdata, memory side)
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int              HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state;
  logic          gnt0_q, gnt1_q;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata_q;
  logic          last;      // port that most recently released the grant
  logic [HW-1:0] hold_cnt;  // transfers in the current grant, saturating

  logic          xfer0, xfer1, rd0, rd1;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          mwe;

  assign xfer0 = gnt0_q & bus.req0;
  assign xfer1 = gnt1_q & bus.req1;
  assign rd0   = xfer0 & ~bus.we0;
  assign rd1   = xfer1 & ~bus.we1;

  // Memory command is driven only by a granted, requesting port; otherwise
  // the memory side is parked at zero so no stray write can occur.
  always_comb begin
    maddr  = '0;
    mwdata = '0;
    mwe    = 1'b0;
    if (xfer0) begin
      maddr  = bus.addr0;
      mwdata = bus.wdata0;
      mwe    = bus.we0;
    end else if (xfer1) begin
      maddr  = bus.addr1;
      mwdata = bus.wdata1;
      mwe    = bus.we1;
    end
  end

  assign bus.maddr   = maddr;
  assign bus.mwdata  = mwdata;
  assign bus.mwe     = mwe;
  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
      last      <= 1'b1;  // port 0 wins the first tie
      hold_cnt  <= '0;
    end else begin
      // Read return: a read on an exit cycle still pulses after the grant moves.
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0 | rd1) rdata_q <= bus.mrdata;

      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (bus.req0 && (!bus.req1 || last)) begin
            state  <= GNT0;
            gnt0_q <= 1'b1;
          end else if (bus.req1) begin
            state  <= GNT1;
            gnt1_q <= 1'b1;
          end
        end

        GNT0: begin
          // Leave on drop of own request, or forced release once the hold
          // window is used up with port 1 waiting (this cycle's transfer
          // still completes).
          if (!bus.req0 || (bus.req1 && hold_cnt == HOLD_LAST)) begin
            last     <= 1'b0;
            hold_cnt <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= bus.req1;
            state    <= bus.req1 ? GNT1 : IDLE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        GNT1: begin
          if (!bus.req1 || (bus.req0 && hold_cnt == HOLD_LAST)) begin
            last     <= 1'b1;
            hold_cnt <= '0;
            gnt1_q   <= 1'b0;
            gnt0_q   <= bus.req0;
            state    <= bus.req0 ? GNT0 : IDLE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule
